// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and state encodings for the data-memory arbiter slice.
package dmem_arbiter_pkg;

   localparam int unsigned M_CORE          = 0;
   localparam int unsigned M_DBG           = 1;
   localparam int unsigned CORE_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker with bounded lock ownership.
// Grants are combinational from state, last winner and requests.
module rr_arb2
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned LOCK_MAX = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] lock,
   output logic [1:0] gnt
);

   localparam int unsigned      CNT_W   = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

   arb_state_e       state, state_nxt;
   logic             last, last_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             owner, owner_busy, win;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      gnt        = '0;
      state_nxt  = IDLE;
      last_nxt   = last;
      cnt_nxt    = '0;
      win        = 1'b0;
      owner      = (state == OWN1);
      owner_busy = (state != IDLE) && req[owner];

      if (owner_busy) begin
         gnt[owner] = 1'b1;
         last_nxt   = owner;
         cnt_nxt    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
         // Release once the beat limit is hit and the other side is waiting.
         if (lock[owner] && !(cnt_nxt == CNT_MAX && req[~owner]))
            state_nxt = state;
         else
            cnt_nxt = '0;
      end else if (|req) begin
         // An idle owner falls straight through to round-robin here.
         win      = (req == 2'b11) ? ~last : req[1];
         gnt[win] = 1'b1;
         last_nxt = win;
         if (lock[win] && !(LOCK_MAX == 1 && req[~win])) begin
            state_nxt = win ? OWN1 : OWN0;
            cnt_nxt   = CNT_W'(1);
         end
      end

      if (rst)
         gnt = '0;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (m0) and debug/loader (m1),
// routing 1-cycle read responses back to the issuing master.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = CORE_DATA_WIDTH,
   parameter int unsigned LOCK_MAX   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    m0_req,
   input  logic                    m0_we,
   input  logic [DATA_WIDTH/8-1:0] m0_be,
   input  logic [ADDR_WIDTH-1:0]   m0_addr,
   input  logic [DATA_WIDTH-1:0]   m0_wdata,
   input  logic                    m0_lock,
   output logic                    m0_gnt,
   output logic                    m0_rvalid,
   output logic [DATA_WIDTH-1:0]   m0_rdata,
   input  logic                    m1_req,
   input  logic                    m1_we,
   input  logic [DATA_WIDTH/8-1:0] m1_be,
   input  logic [ADDR_WIDTH-1:0]   m1_addr,
   input  logic [DATA_WIDTH-1:0]   m1_wdata,
   input  logic                    m1_lock,
   output logic                    m1_gnt,
   output logic                    m1_rvalid,
   output logic [DATA_WIDTH-1:0]   m1_rdata,
   output logic                    mem_en,
   output logic [DATA_WIDTH/8-1:0] mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   logic [1:0]              gnt;
   logic                    sel, sel_we, is_read;
   logic [DATA_WIDTH/8-1:0] sel_be;
   logic                    tag_valid, tag_owner;

   rr_arb2 #(
      .LOCK_MAX (LOCK_MAX)
   ) u_rr_arb2 (
      .clk  (clk),
      .rst  (rst),
      .req  ({m1_req, m0_req}),
      .lock ({m1_lock, m0_lock}),
      .gnt  (gnt)
   );

   assign m0_gnt = gnt[M_CORE];
   assign m1_gnt = gnt[M_DBG];

   always_comb begin
      sel       = gnt[M_DBG];
      mem_en    = |gnt;
      mem_addr  = sel ? m1_addr  : m0_addr;
      mem_wdata = sel ? m1_wdata : m0_wdata;
      sel_we    = sel ? m1_we    : m0_we;
      sel_be    = sel ? m1_be    : m0_be;
      mem_we    = (mem_en && sel_we) ? sel_be : '0;
      is_read   = mem_en && !sel_we;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_valid <= 1'b0;
         tag_owner <= 1'b0;
      end else begin
         tag_valid <= is_read;
         tag_owner <= sel;
      end
   end

   assign m0_rvalid = tag_valid && !tag_owner;
   assign m1_rvalid = tag_valid &&  tag_owner;
   assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
   assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level
// ownership/round-robin model and a reference memory image.
module tb_dmem_arbiter;

   localparam int unsigned LOCK_MAX = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, we, lock;
   logic [3:0]  be    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];

   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;

   logic [31:0] env_mem [64] = '{default: '0};
   logic [31:0] ref_mem [64] = '{default: '0};

   int          n_checks = 0;
   int          n_fail   = 0;
   int          owner, run, last;
   logic [1:0]  exp_rv;
   logic [31:0] exp_rd [2];
   logic [1:0]  granted, obs_gnt, obs_rv;
   logic [31:0] obs_rd0;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .LOCK_MAX   (LOCK_MAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (req[0]),
      .m0_we     (we[0]),
      .m0_be     (be[0]),
      .m0_addr   (addr[0]),
      .m0_wdata  (wdata[0]),
      .m0_lock   (lock[0]),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m1_req    (req[1]),
      .m1_we     (we[1]),
      .m1_be     (be[1]),
      .m1_addr   (addr[1]),
      .m1_wdata  (wdata[1]),
      .m1_lock   (lock[1]),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Single-port memory with 1-cycle read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we != 4'b0000) begin
            for (int b = 0; b < 4; b++)
               if (mem_we[b]) env_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= env_mem[mem_addr[7:2]];
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: check outputs mid-cycle against the model, then advance.
   task automatic step();
      int w;
      int idx;
      @(negedge clk);
      obs_gnt = {m1_gnt, m0_gnt};
      obs_rv  = {m1_rvalid, m0_rvalid};
      obs_rd0 = m0_rdata;
      granted = '0;
      if (rst) begin
         check_eq("rst_gnt",      32'(obs_gnt), 0);
         check_eq("rst_mem_en",   32'(mem_en), 0);
         check_eq("rst_mem_we",   32'(mem_we), 0);
         check_eq("rst_rvalid",   32'(obs_rv), 0);
         check_eq("rst_m0_rdata", m0_rdata, 0);
         check_eq("rst_m1_rdata", m1_rdata, 0);
         owner  = -1;
         run    = 0;
         last   = 1;
         exp_rv = '0;
      end else begin
         check_eq("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv[0]));
         check_eq("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv[1]));
         check_eq("m0_rdata",  m0_rdata, exp_rv[0] ? exp_rd[0] : 32'd0);
         check_eq("m1_rdata",  m1_rdata, exp_rv[1] ? exp_rd[1] : 32'd0);
         w = -1;
         if (owner >= 0 && req[owner]) begin
            w = owner;
         end else begin
            owner = -1;
            run   = 0;
            if (req == 2'b11)  w = 1 - last;
            else if (req[0])   w = 0;
            else if (req[1])   w = 1;
         end
         check_eq("gnt",    32'(obs_gnt), (w < 0) ? 0 : (1 << w));
         check_eq("mem_en", 32'(mem_en), (w >= 0) ? 1 : 0);
         exp_rv = '0;
         if (w >= 0) begin
            granted[w] = 1'b1;
            idx = int'(addr[w][7:2]);
            check_eq("mem_addr", mem_addr, addr[w]);
            check_eq("mem_we", 32'(mem_we), we[w] ? 32'(be[w]) : 32'd0);
            if (we[w]) begin
               check_eq("mem_wdata", mem_wdata, wdata[w]);
               for (int b = 0; b < 4; b++)
                  if (be[w][b]) ref_mem[idx][8*b +: 8] = wdata[w][8*b +: 8];
            end else begin
               exp_rv[w] = 1'b1;
               exp_rd[w] = ref_mem[idx];
            end
            if (owner == w) run++;
            else if (lock[w]) begin
               owner = w;
               run   = 1;
            end
            if (!lock[w] || (run >= LOCK_MAX && req[1-w])) begin
               owner = -1;
               run   = 0;
            end
            last = w;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input int m, input logic w_e, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic lk);
      int n;
      n = 0;
      req[m] = 1'b1; we[m] = w_e; addr[m] = a; wdata[m] = d; be[m] = b; lock[m] = lk;
      do begin
         step();
         n++;
      end while (!granted[m] && n < 64);
      check_eq("xfer_gnt", 32'(granted[m]), 1);
      req[m]  = 1'b0;
      lock[m] = 1'b0;
   endtask

   initial begin
      bit [1:0] pending;
      int       burst [2];
      int       exp_g;

      rst = 1'b1; req = 2'b11; we = '0; lock = '0;
      for (int m = 0; m < 2; m++) begin
         be[m] = '0; addr[m] = '0; wdata[m] = '0; exp_rd[m] = '0; burst[m] = 0;
      end
      owner = -1; run = 0; last = 1; exp_rv = '0; pending = '0;

      // Reset held with both masters requesting, then m0 wins the first tie.
      repeat (3) step();
      rst = 1'b0;
      step();
      check_eq("first_gnt_after_rst", 32'(obs_gnt), 1);
      req = '0;
      step();

      // Partial-byte write followed by a read-back.
      xfer(1, 1'b1, 32'h8, 32'hDEADBEEF, 4'b0011, 1'b0);
      xfer(0, 1'b0, 32'h8, 32'h0, 4'b0000, 1'b0);
      step();
      check_eq("be_readback", obs_rd0, 32'h0000BEEF);

      // Tie round-robin on continuous reads.
      xfer(0, 1'b1, 32'h10, 32'h11111111, 4'hF, 1'b0);
      xfer(1, 1'b1, 32'h20, 32'h22222222, 4'hF, 1'b0);
      req = 2'b11; we = 2'b00; addr[0] = 32'h10; addr[1] = 32'h20;
      for (int c = 0; c < 8; c++) begin
         step();
         check_eq("tie_alternate", 32'(obs_gnt), (c % 2 == 0) ? 1 : 2);
      end
      req = '0;
      step();

      // Lock limit: m1 bursts with lock while m0 keeps asking.
      req = 2'b10; lock = 2'b10;
      step();
      check_eq("lock_first", 32'(obs_gnt), 2);
      req = 2'b11;
      for (int c = 1; c < 40; c++) begin
         exp_g = (c == 16 || c == 33) ? 1 : 2;
         step();
         check_eq("lock_limit_seq", 32'(obs_gnt), exp_g);
      end
      req = '0; lock = '0;
      step();

      // Locked master idles for one cycle: the waiting master gets in at once.
      req = 2'b10; lock = 2'b10;
      step();
      req = 2'b11;
      step();
      step();
      check_eq("lock_hold", 32'(obs_gnt), 2);
      req[1] = 1'b0;
      step();
      check_eq("lock_idle_release", 32'(obs_gnt), 1);
      req = '0; lock = '0;
      step();

      // Reset in the cycle after a granted read drops the response.
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
      rst = 1'b1;
      step();
      check_eq("midread_rvalid", 32'(obs_rv), 0);
      rst = 1'b0;
      req = 2'b11; we = 2'b00;
      step();
      check_eq("post_rst_rr", 32'(obs_gnt), 1);
      req = '0;
      step();

      // Randomized traffic with lock bursts and occasional resets.
      for (int c = 0; c < 2500; c++) begin
         for (int m = 0; m < 2; m++) begin
            if (!pending[m]) begin
               if ($urandom_range(0, 99) < ((burst[m] > 0) ? 90 : 55)) begin
                  pending[m] = 1'b1;
                  req[m]     = 1'b1;
                  we[m]      = 1'($urandom_range(0, 1));
                  addr[m]    = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                  wdata[m]   = $urandom;
                  be[m]      = 4'($urandom_range(0, 15));
                  if (burst[m] == 0 && $urandom_range(0, 99) < 8)
                     burst[m] = $urandom_range(1, 40);
                  lock[m] = (burst[m] > 0);
                  if (burst[m] > 0) burst[m]--;
               end else begin
                  req[m]  = 1'b0;
                  lock[m] = 1'b0;
               end
            end
         end
         rst = ($urandom_range(0, 399) == 0);
         step();
         pending = pending & ~granted;
      end
      rst = 1'b0; req = '0; lock = '0;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
